// File: rtl/register_bank_pkg.sv
// ============================================================================
// Module  : register_bank_pkg
// Brief   : Shared defaults and slot-index helper for the register bank.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package register_bank_pkg;

  localparam int REGBANK_WIDTH_DEF = 4;
  localparam int REGBANK_NREG_DEF  = 2;

  // LSB position of slot idx inside the flat REG_Q vector.
  function automatic int reg_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_bank_counter_slice.sv
// ============================================================================
// Module  : counter_slice
// Brief   : One WIDTH-bit 74HC161-style counter: sync load, count enable, RCO.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_slice
  import register_bank_pkg::*;
#(
  parameter int WIDTH = REGBANK_WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             nLOAD,
  input  logic             CNT_EN,
  input  logic [WIDTH-1:0] DATAIN,
  output logic [WIDTH-1:0] Q,
  output logic             CO
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load outranks count, so a simultaneous load never increments.
  always_comb begin
    cnt_d = cnt_q;
    if (!nLOAD) begin
      cnt_d = DATAIN;
    end else if (CNT_EN) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Q  = cnt_q;
  assign CO = (&cnt_q) & CNT_EN;

endmodule

`default_nettype wire

// File: rtl/register_bank.sv
// ============================================================================
// Module  : register_bank
// Brief   : NREG loadable counters with shared store/load buses, per-slot
//           carry and a sticky bus-contention flag.
//           Build option REGISTER_BANK_TRISTATE_EN: LOADDATA floats to 'z'
//           when no output enable is active (otherwise it reads 0).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module register_bank
  import register_bank_pkg::*;
#(
  parameter int WIDTH = REGBANK_WIDTH_DEF,
  parameter int NREG  = REGBANK_NREG_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREG-1:0]       nST,
  input  logic [NREG-1:0]       CNT_EN,
  input  logic [NREG-1:0]       nOUT,
  input  logic [WIDTH-1:0]      STOREDATA,
  output logic [WIDTH-1:0]      LOADDATA,
  output logic [NREG-1:0]       CO,
  output logic                  BUS_CONFLICT,
  output logic [NREG*WIDTH-1:0] REG_Q
);

  logic [WIDTH-1:0] slice_q [NREG];
  logic [WIDTH-1:0] mux_data;
  logic [NREG-1:0]  oe;
  logic             any_oe;
  logic             multi_oe;
  logic             conflict_q;
  logic             conflict_d;

  generate
    for (genvar i = 0; i < NREG; i++) begin : g_slice
      localparam int LSB = reg_lsb(i, WIDTH);

      counter_slice #(
        .WIDTH (WIDTH)
      ) u_slice (
        .CLK    (CLK),
        .RST    (RST),
        .nLOAD  (nST[i]),
        .CNT_EN (CNT_EN[i]),
        .DATAIN (STOREDATA),
        .Q      (slice_q[i]),
        .CO     (CO[i])
      );

      assign REG_Q[LSB +: WIDTH] = slice_q[i];
    end
  endgenerate

  assign oe     = ~nOUT;
  assign any_oe = |oe;
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_oe = |(oe & (oe - NREG'(1)));

  // Scan high to low so the lowest-index enabled slot wins on contention.
  always_comb begin
    mux_data = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (oe[i]) begin
        mux_data = slice_q[i];
      end
    end
  end

`ifdef REGISTER_BANK_TRISTATE_EN
  assign LOADDATA = any_oe ? mux_data : {WIDTH{1'bz}};
`else
  assign LOADDATA = any_oe ? mux_data : '0;
`endif

  always_comb begin
    conflict_d = conflict_q | multi_oe;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign BUS_CONFLICT = conflict_q;

endmodule

`default_nettype wire

// File: tb/tb_register_bank.sv
// ============================================================================
// Module  : tb_register_bank
// Brief   : Scoreboard-driven bench for register_bank (4x2 and 8x4 builds).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_register_bank;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic [1:0] nst, cnt_en, nout;
  logic [3:0] sd, ld;
  logic [1:0] co;
  logic       bc;
  logic [7:0] regq;

  logic [3:0]  nst1, cnt1, nout1, co1;
  logic [7:0]  sd1, ld1;
  logic        bc1;
  logic [31:0] regq1;

`ifdef REGISTER_BANK_TRISTATE_EN
  logic [3:0] idle4 = 4'bzzzz;
  logic [7:0] idle8 = 8'bzzzzzzzz;
`else
  logic [3:0] idle4 = 4'h0;
  logic [7:0] idle8 = 8'h00;
`endif

  register_bank #(.WIDTH(4), .NREG(2)) u_dut (
    .CLK(CLK), .RST(RST), .nST(nst), .CNT_EN(cnt_en), .nOUT(nout),
    .STOREDATA(sd), .LOADDATA(ld), .CO(co), .BUS_CONFLICT(bc), .REG_Q(regq)
  );

  register_bank #(.WIDTH(8), .NREG(4)) u_dut8 (
    .CLK(CLK), .RST(RST), .nST(nst1), .CNT_EN(cnt1), .nOUT(nout1),
    .STOREDATA(sd1), .LOADDATA(ld1), .CO(co1), .BUS_CONFLICT(bc1), .REG_Q(regq1)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_v;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; nout = 2'b11; nout1 = 4'hF; sd = 4'h5; sd1 = 8'h55;
    for (int k = 0; k < 2; k++) begin
      nst = 2'($urandom); cnt_en = 2'($urandom);
      nst1 = 4'($urandom); cnt1 = 4'($urandom);
      tick();
    end
    nst = 2'b11; cnt_en = 2'b00; nst1 = 4'hF; cnt1 = 4'h0;
    #1;
    sb.push_back(32'h0);
    exp_v = sb.pop_front();
    checks++; if (regq !== exp_v[7:0]) begin failures++; $display("FAIL reset_regq got=%h exp=%h", regq, exp_v[7:0]); end
    checks++; if (co !== 2'b00) begin failures++; $display("FAIL reset_co got=%b exp=00", co); end
    checks++; if (bc !== 1'b0) begin failures++; $display("FAIL reset_bc got=%b exp=0", bc); end
    checks++; if (ld !== idle4) begin failures++; $display("FAIL reset_ld got=%h exp=%h", ld, idle4); end
    checks++; if (regq1 !== 32'h0 || bc1 !== 1'b0 || ld1 !== idle8) begin
      failures++; $display("FAIL reset_w8 got regq=%h bc=%b ld=%h exp 0/0/%h", regq1, bc1, ld1, idle8);
    end
    RST = 1'b0;
  endtask

  task automatic test_load_read();
    nst = 2'b10; sd = 4'hA; sb.push_back(32'hA);
    tick();
    nst = 2'b11; nout = 2'b10; #1;
    exp_v = sb.pop_front();
    checks++; if (ld !== exp_v[3:0]) begin failures++; $display("FAIL load_read_ld got=%h exp=%h", ld, exp_v[3:0]); end
    checks++; if (regq[7:4] !== 4'h0) begin failures++; $display("FAIL load_read_reg1 got=%h exp=0", regq[7:4]); end
    nout = 2'b11;
  endtask

  task automatic test_wrap_carry();
    nst = 2'b10; sd = 4'hE;
    tick();
    nst = 2'b11; cnt_en = 2'b01; #1;
    checks++; if (co[0] !== 1'b0) begin failures++; $display("FAIL carry_at_E got=%b exp=0", co[0]); end
    sb.push_back({27'd0, 1'b1, 4'hF});
    sb.push_back({27'd0, 1'b0, 4'h0});
    sb.push_back({27'd0, 1'b0, 4'h1});
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_v = sb.pop_front();
      checks++; if (regq[3:0] !== exp_v[3:0] || co[0] !== exp_v[4]) begin
        failures++; $display("FAIL wrap_step%0d got val=%h co=%b exp val=%h co=%b", k, regq[3:0], co[0], exp_v[3:0], exp_v[4]);
      end
    end
    cnt_en = 2'b00;
  endtask

  task automatic test_load_beats_count();
    nst = 2'b01; sd = 4'h3;
    tick();
    cnt_en = 2'b10; sd = 4'h7; nout = 2'b01; sb.push_back(32'h7); #1;
    checks++; if (ld !== 4'h3) begin failures++; $display("FAIL ld_old_value got=%h exp=3", ld); end
    tick();
    exp_v = sb.pop_front();
    checks++; if (regq[7:4] !== exp_v[3:0]) begin failures++; $display("FAIL load_beats_count got=%h exp=%h", regq[7:4], exp_v[3:0]); end
    sd = 4'hF;
    tick();
    // reg1 now F; nST still low with CNT_EN high must still raise CO
    #1;
    checks++; if (co[1] !== 1'b1) begin failures++; $display("FAIL co_ignores_nst got=%b exp=1", co[1]); end
    nst = 2'b11; cnt_en = 2'b00; nout = 2'b11;
  endtask

  task automatic test_conflict();
    nst = 2'b10; sd = 4'h5; tick();
    nst = 2'b01; sd = 4'h9; tick();
    nst = 2'b11; nout = 2'b00; sb.push_back(32'h5); #1;
    exp_v = sb.pop_front();
    checks++; if (ld !== exp_v[3:0]) begin failures++; $display("FAIL conflict_ld got=%h exp=%h", ld, exp_v[3:0]); end
    checks++; if (bc !== 1'b0) begin failures++; $display("FAIL conflict_pre_edge got=%b exp=0", bc); end
    tick();
    checks++; if (bc !== 1'b1) begin failures++; $display("FAIL conflict_set got=%b exp=1", bc); end
    nout = 2'b11; tick(); tick();
    checks++; if (bc !== 1'b1 || ld !== idle4) begin failures++; $display("FAIL conflict_sticky got bc=%b ld=%h exp 1/%h", bc, ld, idle4); end
    nout = 2'b10; #1;
    checks++; if (ld !== 4'h5) begin failures++; $display("FAIL single_oe_reg0 got=%h exp=5", ld); end
    RST = 1'b1; nout = 2'b00; cnt_en = 2'b11; nst = 2'b00;
    tick();
    checks++; if (bc !== 1'b0 || regq !== 8'h00) begin failures++; $display("FAIL rst_priority got bc=%b regq=%h exp 0/00", bc, regq); end
    RST = 1'b0; nout = 2'b11; cnt_en = 2'b00; nst = 2'b11;
    tick();
    checks++; if (bc !== 1'b0) begin failures++; $display("FAIL post_rst_bc got=%b exp=0", bc); end
  endtask

  task automatic test_param_sweep();
    nst1 = 4'b1110; sd1 = 8'h12; tick();
    nst1 = 4'b0111; sd1 = 8'hFF; tick();
    nst1 = 4'hF; cnt1 = 4'b1000; #1;
    checks++; if (co1 !== 4'b1000) begin failures++; $display("FAIL w8_co_pre got=%b exp=1000", co1); end
    sb.push_back({8'h00, 8'h00, 8'h00, 8'h12});
    tick();
    exp_v = sb.pop_front();
    checks++; if (regq1 !== exp_v) begin failures++; $display("FAIL w8_wrap got=%h exp=%h", regq1, exp_v); end
    checks++; if (co1 !== 4'b0000) begin failures++; $display("FAIL w8_co_post got=%b exp=0000", co1); end
    cnt1 = 4'h0; nout1 = 4'b0110; #1;
    checks++; if (ld1 !== 8'h12) begin failures++; $display("FAIL w8_lowest_oe got=%h exp=12", ld1); end
    tick();
    checks++; if (bc1 !== 1'b1) begin failures++; $display("FAIL w8_conflict got=%b exp=1", bc1); end
    nout1 = 4'hF;
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_wrap_carry();
    test_load_beats_count();
    test_conflict();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
